// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port 256x64 RAM slave.
// Accepts one command at a time and either streams write data into consecutive
// RAM addresses (one word per cycle peak) or reads consecutive words back out
// through a valid/ready stream (issue, wait, hold: three cycles per word).
// All RAM control pins and read-stream outputs are registered.
module ram_burst_master #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rd,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  // write-data stream
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  // read-data stream
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  // RAM slave port
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_din,
  input  logic [DW-1:0] s_dout,
  // status
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state_q,    state_d;
  logic [AW-1:0] ptr_q,      ptr_d;
  logic [AW:0]   remain_q,   remain_d;
  logic          cen_q,      cen_d;
  logic          wen_q,      wen_d;
  logic [AW-1:0] s_addr_q,   s_addr_d;
  logic [DW-1:0] s_din_q,    s_din_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q,  rd_data_d;

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    cen_d      = 1'b0;          // RAM strobes are single-cycle unless re-armed
    wen_d      = 1'b0;
    s_addr_d   = s_addr_q;
    s_din_d    = s_din_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ptr_d    = cmd_addr;
          remain_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else if (cmd_rd) begin
            // The read strobe is armed on the edge entering RD_ISSUE so the
            // RAM sees the read during RD_ISSUE and returns data in RD_WAIT.
            state_d  = S_RD_ISSUE;
            cen_d    = 1'b1;
            s_addr_d = cmd_addr;
          end else begin
            state_d = S_WR;
          end
        end
      end

      S_WR: begin
        if (wr_valid) begin
          cen_d    = 1'b1;
          wen_d    = 1'b1;
          s_addr_d = ptr_q;
          s_din_d  = wr_data;
          ptr_d    = ptr_q + AW'(1);          // wraps modulo 2^AW
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_RD_ISSUE: begin
        ptr_d    = ptr_q + AW'(1);
        remain_d = remain_q - (AW+1)'(1);
        state_d  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        rd_data_d  = s_dout;
        rd_valid_d = 1'b1;
        state_d    = S_RD_HOLD;
      end

      S_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (remain_q != '0) begin
            state_d  = S_RD_ISSUE;
            cen_d    = 1'b1;
            s_addr_d = ptr_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      cen_q      <= 1'b0;
      wen_q      <= 1'b0;
      s_addr_q   <= '0;
      s_din_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      s_addr_q   <= s_addr_d;
      s_din_q    <= s_din_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  assign cen       = cen_q;
  assign wen       = wen_q;
  assign s_addr    = s_addr_q;
  assign s_din     = s_din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: a behavioural 256x64 RAM slave, a reference
// memory image updated from the burst rules, and per-scenario tasks.
module tb_ram_burst_master;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_rd = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          cmd_ready, wr_ready, rd_valid, cen, wen, busy, done;
  logic [DW-1:0] rd_data, s_din;
  logic [DW-1:0] s_dout = '0;
  logic [AW-1:0] s_addr;

  ram_burst_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: write commits at the edge ending the presented cycle; read
  // data appears in the cycle after the read is presented, 0 otherwise.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (cen && wen) ram[s_addr] <= s_din;
    s_dout <= (cen && !wen) ? ram[s_addr] : '0;
  end

  // Reference memory image and stimulus storage.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wdat [256];
  logic [DW-1:0] rq [$];
  int            hs_q [$];

  // Monitor of RAM port activity, sampled mid-cycle.
  int            wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            wr_cyc_q [$];
  int            rd_addr_q [$];
  int            rd_cyc_q [$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            viol = 0;

  always @(negedge clk) begin
    if (cen && wen) begin
      wr_addr_q.push_back(int'(s_addr));
      wr_data_q.push_back(s_din);
      wr_cyc_q.push_back(cyc);
    end
    if (cen && !wen) begin
      rd_addr_q.push_back(int'(s_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wen && !cen) viol++;
    if (cen && cmd_ready) viol++;
  end

  function automatic logic [DW-1:0] init_word(int i);
    return {32'hC0DE0000 + 32'(i), 32'(i) * 32'h9E3779B9};
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL idle_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
    end
  endtask

  // Presents one command and returns the cycle that starts at its acceptance.
  task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [AW:0] n,
                          output int acc);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_len = n;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Streams wdat[0..len-1]; bubble<0 alternates valid, else percent idle.
  task automatic drive_write(input int len, input int bubble, input int poke_at,
                             output int n_hs);
    int sent = 0;
    int it = 0;
    logic v, r;
    hs_q.delete();
    while (sent < len && it < 2000) begin
      v = (bubble < 0) ? ((it % 2) == 0) : (int'($urandom_range(99)) >= bubble);
      wr_valid = v;
      wr_data  = v ? wdat[sent] : {$urandom, $urandom};
      r = wr_ready;
      if (it == poke_at) begin
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 8'h11; cmd_len = 9'd5;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      if (v && r) begin
        sent++;
        hs_q.push_back(cyc);
      end
      it++;
    end
    wr_valid = 1'b0;
    n_hs = sent;
  endtask

  // mode 0: ready held; 1: random ready; 2: four stall cycles on word 2.
  task automatic drive_read(input int len, input int mode, output int first_v,
                            output int stalls);
    int got = 0;
    int it = 0;
    logic r;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_d = '0;
    first_v = -1;
    stalls = 0;
    while (got < len && it < 3000) begin
      if (rd_valid && first_v < 0) first_v = cyc;
      if (prev_hold) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_d) begin
          errs++;
          $display("FAIL rd_hold: rd_valid=%b rd_data=%h, required 1 / %h", rd_valid, rd_data, prev_d);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(1));
        default: r = !(got == 1 && rd_valid && stalls < 4);
      endcase
      if (mode == 2 && got == 1 && rd_valid && !r) stalls++;
      rd_ready = r;
      prev_hold = rd_valid && !r;
      prev_d = rd_data;
      if (rd_valid && r) begin
        rq.push_back(rd_data);
        got++;
      end
      @(negedge clk);
      it++;
    end
    rd_ready = 1'b0;
  endtask

  // Full write scenario against the reference rules; updates ref_mem.
  task automatic run_write_burst(input logic [AW-1:0] a, input int len, input int bubble,
                                 input int poke_at, output int acc);
    int d0, n_hs, ea;
    for (int i = 0; i < len; i++) wdat[i] = {$urandom, $urandom};
    clear_mon();
    d0 = done_cnt;
    send_cmd(1'b0, a, (AW+1)'(len), acc);
    drive_write(len, bubble, poke_at, n_hs);
    wait_idle();
    checks++;
    if (n_hs != len) begin
      errs++;
      $display("FAIL wr_handshakes: got %0d, required %0d", n_hs, len);
    end
    checks++;
    if (wr_addr_q.size() != len) begin
      errs++;
      $display("FAIL wr_count: %0d RAM writes, required %0d", wr_addr_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        ea = (int'(a) + i) % 256;
        checks++;
        if (wr_addr_q[i] != ea || wr_data_q[i] !== wdat[i] || wr_cyc_q[i] != hs_q[i]) begin
          errs++;
          $display("FAIL wr_word[%0d]: addr=%h data=%h cyc=%0d, required %h %h %0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], ea, wdat[i], hs_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL wr_done_count: %0d pulses, required 1", done_cnt - d0);
    end
    if (len > 0 && n_hs == len) begin
      checks++;
      if (done_cyc != hs_q[len-1]) begin
        errs++;
        $display("FAIL wr_done_cycle: done in cycle %0d, required %0d", done_cyc, hs_q[len-1]);
      end
    end
    checks++;
    if (rd_addr_q.size() != 0) begin
      errs++;
      $display("FAIL wr_no_reads: %0d RAM reads, required 0", rd_addr_q.size());
    end
    for (int i = 0; i < len; i++) ref_mem[(int'(a) + i) % 256] = wdat[i];
  endtask

  // Full read scenario against ref_mem.
  task automatic run_read_burst(input logic [AW-1:0] a, input int len, input int mode,
                                output int acc, output int first_v, output int stalls);
    int d0, ea;
    clear_mon();
    rq.delete();
    d0 = done_cnt;
    send_cmd(1'b1, a, (AW+1)'(len), acc);
    drive_read(len, mode, first_v, stalls);
    wait_idle();
    checks++;
    if (rq.size() != len) begin
      errs++;
      $display("FAIL rd_count: %0d words delivered, required %0d", rq.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        checks++;
        if (rq[i] !== ref_mem[(int'(a) + i) % 256]) begin
          errs++;
          $display("FAIL rd_word[%0d]: got %h, required %h", i, rq[i], ref_mem[(int'(a) + i) % 256]);
        end
      end
    end
    checks++;
    if (rd_addr_q.size() != len) begin
      errs++;
      $display("FAIL rd_ram_reads: %0d RAM reads, required %0d", rd_addr_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        ea = (int'(a) + i) % 256;
        checks++;
        if (rd_addr_q[i] != ea) begin
          errs++;
          $display("FAIL rd_addr[%0d]: got %h, required %h", i, rd_addr_q[i], ea);
        end
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errs++;
      $display("FAIL rd_done_count: %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (wr_addr_q.size() != 0) begin
      errs++;
      $display("FAIL rd_no_writes: %0d RAM writes, required 0", wr_addr_q.size());
    end
  endtask

  task automatic test_reset();
    int acc, d0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cen, wen, busy, done, rd_valid} !== 5'b0 || s_addr !== '0 || s_din !== '0 || rd_data !== '0) begin
      errs++;
      $display("FAIL reset_values: cen=%b wen=%b busy=%b done=%b rd_valid=%b s_addr=%h s_din=%h rd_data=%h, required all 0",
               cen, wen, busy, done, rd_valid, s_addr, s_din, rd_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 / 0", cmd_ready, busy);
    end
    d0 = done_cnt;
    send_cmd(1'b0, 8'h40, 9'd4, acc);
    wr_valid = 1'b1;
    wr_data  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    checks++;
    if (cen !== 1'b1 || wen !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL midburst_active: cen=%b wen=%b busy=%b, required 1 1 1", cen, wen, busy);
    end
    #2 reset_n = 1'b0;
    wr_valid = 1'b0;
    #1;
    checks++;
    if ({cen, wen, busy, rd_valid, done} !== 5'b0) begin
      errs++;
      $display("FAIL reset_midburst: cen=%b wen=%b busy=%b rd_valid=%b done=%b, required all 0",
               cen, wen, busy, rd_valid, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      errs++;
      $display("FAIL reset_no_done: cmd_ready=%b busy=%b done pulses=%0d, required 1 0 0",
               cmd_ready, busy, done_cnt - d0);
    end
    clear_mon();
  endtask

  task automatic test_write_basic();
    int acc;
    // fixed stream 1, 2 to 8'haa with wr_valid held
    clear_mon();
    wdat[0] = 64'h1;
    wdat[1] = 64'h2;
    send_cmd(1'b0, 8'haa, 9'd2, acc);
    wr_valid = 1'b1; wr_data = 64'h1;
    @(negedge clk);
    wr_data = 64'h2;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_idle();
    checks++;
    if (wr_addr_q.size() != 2) begin
      errs++;
      $display("FAIL wbasic_count: %0d writes, required 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] != 'haa || wr_data_q[0] !== 64'h1 || wr_cyc_q[0] != acc + 1 ||
          wr_addr_q[1] != 'hab || wr_data_q[1] !== 64'h2 || wr_cyc_q[1] != acc + 2) begin
        errs++;
        $display("FAIL wbasic_writes: %h=%h@%0d %h=%h@%0d, required aa=1@%0d ab=2@%0d",
                 wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], wr_addr_q[1], wr_data_q[1], wr_cyc_q[1],
                 acc + 1, acc + 2);
      end
    end
    checks++;
    if (done_cyc != acc + 2) begin
      errs++;
      $display("FAIL wbasic_done: done in cycle %0d, required %0d", done_cyc, acc + 2);
    end
    ref_mem[8'haa] = 64'h1;
    ref_mem[8'hab] = 64'h2;
  endtask

  task automatic test_read_basic();
    int acc, fv, st;
    run_read_burst(8'haa, 2, 0, acc, fv, st);
    checks++;
    if (rq.size() == 2 && (rq[0] !== 64'h1 || rq[1] !== 64'h2)) begin
      errs++;
      $display("FAIL rbasic_data: %h %h, required 1 2", rq[0], rq[1]);
    end
    checks++;
    if (fv != acc + 2) begin
      errs++;
      $display("FAIL rbasic_first_valid: cycle %0d, required %0d", fv, acc + 2);
    end
    checks++;
    if (rd_cyc_q.size() != 2 || rd_cyc_q[0] != acc || rd_cyc_q[1] != acc + 3) begin
      errs++;
      $display("FAIL rbasic_issue_cycles: %0d reads, first at %0d, required 2 at %0d and %0d",
               rd_cyc_q.size(), rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, acc, acc + 3);
    end
    checks++;
    if (done_cyc != acc + 6) begin
      errs++;
      $display("FAIL rbasic_done: cycle %0d, required %0d", done_cyc, acc + 6);
    end
  endtask

  task automatic test_backpressure();
    int acc, fv, st;
    logic [AW-1:0] a;
    a = AW'($urandom_range(255));
    run_write_burst(a, 3, 0, -1, acc);
    run_read_burst(a, 3, 2, acc, fv, st);
    checks++;
    if (st != 4) begin
      errs++;
      $display("FAIL bp_stalls: %0d stall cycles applied, required 4", st);
    end
    checks++;
    if (rd_cyc_q.size() != 3 || rd_cyc_q[2] - rd_cyc_q[1] != 7) begin
      errs++;
      $display("FAIL bp_issue_spacing: %0d reads, required 3 with word 3 issued 7 cycles after word 2",
               rd_cyc_q.size());
    end
  endtask

  task automatic test_wrap_bubbles();
    int acc, fv, st;
    run_write_burst(8'hfe, 4, -1, -1, acc);
    checks++;
    if (wr_cyc_q.size() != 4 || wr_cyc_q[1] - wr_cyc_q[0] != 2 || wr_addr_q[2] != 0) begin
      errs++;
      $display("FAIL wrap_bubbles: %0d writes, required 4 every other cycle wrapping to 00",
               wr_cyc_q.size());
    end
    run_read_burst(8'hfe, 4, 1, acc, fv, st);
  endtask

  task automatic test_zero_len();
    int acc, fv, st;
    run_write_burst(AW'($urandom_range(255)), 0, 0, -1, acc);
    checks++;
    if (done_cyc != acc || wr_addr_q.size() != 0) begin
      errs++;
      $display("FAIL zero_wr: done cycle %0d writes %0d, required %0d / 0", done_cyc, wr_addr_q.size(), acc);
    end
    run_read_burst(AW'($urandom_range(255)), 0, 0, acc, fv, st);
    checks++;
    if (done_cyc != acc || rd_addr_q.size() != 0) begin
      errs++;
      $display("FAIL zero_rd: done cycle %0d reads %0d, required %0d / 0", done_cyc, rd_addr_q.size(), acc);
    end
  endtask

  task automatic test_ignored_cmd();
    int acc;
    // a read command pulsed mid-write must not start a second burst
    run_write_burst(8'h30, 3, 30, 1, acc);
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_addr_q.size() != 0) begin
      errs++;
      $display("FAIL ignored_cmd: busy=%b reads=%0d, required 0 / 0", busy, rd_addr_q.size());
    end
  endtask

  task automatic test_random_bursts();
    int acc, fv, st, len, off, len2;
    logic [AW-1:0] a;
    for (int k = 0; k < 6; k++) begin
      a   = AW'($urandom_range(255));
      len = $urandom_range(1, 40);
      run_write_burst(a, len, $urandom_range(0, 60), -1, acc);
      off  = $urandom_range(0, len - 1);
      len2 = $urandom_range(1, len - off);
      run_read_burst(a + AW'(off), len2, 1, acc, fv, st);
    end
    a = AW'($urandom_range(255));
    run_write_burst(a, 256, 0, -1, acc);
    run_read_burst(a + 8'd17, 256, 0, acc, fv, st);
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      errs++;
      $display("FAIL ram_pin_invariants: %0d cycles with wen w/o cen or cen in IDLE, required 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_backpressure();
    test_wrap_bubbles();
    test_zero_len();
    test_ignored_cmd();
    test_random_bursts();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
